// File: rtl/bfs_pkg.sv
// Shared allocator definitions: default PU count, count-width helper, FSM encodings, node classes.
package bfs_pkg;

  localparam int NUM_PU_DFLT = 16;

  // Counts must hold the value NUM_PU itself, hence the extra bit.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  typedef enum logic [1:0] {
    NC_NORMAL = 2'b00,
    NC_MEDIUM = 2'b01,
    NC_HIGH   = 2'b10
  } node_class_e;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_FREE = 2'd1;
  localparam logic [1:0] ST_ALLOC     = 2'd2;
  localparam logic [1:0] ST_GRANT     = 2'd3;

endpackage

// File: rtl/pu_find_first.sv
// Combinational lowest-set-bit picker: one-hot of the least significant 1 in vec.
module pu_find_first
  import bfs_pkg::*;
#(
  parameter int W = NUM_PU_DFLT
) (
  input  logic [W-1:0] vec,
  output logic [W-1:0] onehot,
  output logic         found
);

  assign onehot = vec & (~vec + W'(1));
  assign found  = |vec;

endmodule

// File: rtl/pu_allocator.sv
// PU pool allocator: reserves one lowest-free PU per cycle, then holds the grant until accepted.
// Define PU_ALLOC_PARTIAL_EN to grant min(count, free) PUs instead of waiting for the full count.
module pu_allocator
  import bfs_pkg::*;
#(
  parameter int NUM_PU = NUM_PU_DFLT,
  parameter int CW     = cnt_w(NUM_PU)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CW-1:0]     req_count,
  input  logic [7:0]        req_tag,
  output logic              grant_valid,
  input  logic              grant_ready,
  output logic [NUM_PU-1:0] grant_mask,
  output logic [7:0]        grant_tag,
  input  logic              rel_valid,
  input  logic [NUM_PU-1:0] rel_mask,
  output logic [CW-1:0]     free_count,
  output logic              rel_err
);

  logic [1:0]        state, state_nxt;
  logic [NUM_PU-1:0] busy, pend, busy_nxt, pend_nxt, pick, rel_hit;
  logic [CW-1:0]     need, need_nxt, eff, pop;
  logic [7:0]        tag;
  logic              ready_en, found, hs;

  pu_find_first #(.W(NUM_PU)) u_ff (
    .vec    (~(busy | pend)),
    .onehot (pick),
    .found  (found)
  );

  always_comb begin
    if (req_count == '0)               eff = CW'(1);
    else if (req_count > CW'(NUM_PU))  eff = CW'(NUM_PU);
    else                               eff = req_count;
  end

  // ready_en keeps req_ready low until the first edge after reset release.
`ifdef PU_ALLOC_PARTIAL_EN
  assign req_ready = ready_en && (state == ST_IDLE) && (free_count != '0);
`else
  assign req_ready = ready_en && (state == ST_IDLE);
`endif

  assign hs          = req_valid && req_ready;
  assign rel_hit     = rel_valid ? (rel_mask & busy) : '0;
  assign grant_valid = (state == ST_GRANT);
  assign grant_mask  = grant_valid ? pend : '0;
  assign grant_tag   = tag;

  always_comb begin
    state_nxt = state;
    need_nxt  = need;
    busy_nxt  = busy & ~rel_hit;
    pend_nxt  = pend;
    case (state)
      ST_IDLE: if (hs) begin
`ifdef PU_ALLOC_PARTIAL_EN
        need_nxt  = (free_count < eff) ? free_count : eff;
        state_nxt = ST_ALLOC;
`else
        need_nxt  = eff;
        state_nxt = (free_count >= eff) ? ST_ALLOC : ST_WAIT_FREE;
`endif
      end
      ST_WAIT_FREE: if (free_count >= need) state_nxt = ST_ALLOC;
      ST_ALLOC: begin
        if (need == '0) state_nxt = ST_GRANT;
        else if (found) begin
          pend_nxt = pend | pick;
          need_nxt = need - CW'(1);
        end
      end
      ST_GRANT: if (grant_ready) begin
        busy_nxt  = busy_nxt | pend;
        pend_nxt  = '0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // free_count tracks the post-edge pool so it is exact the cycle after any change.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_PU; i++) pop = pop + CW'(busy_nxt[i] | pend_nxt[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= '0;
      pend       <= '0;
      need       <= '0;
      tag        <= '0;
      free_count <= CW'(NUM_PU);
      rel_err    <= 1'b0;
      ready_en   <= 1'b0;
    end else begin
      state      <= state_nxt;
      busy       <= busy_nxt;
      pend       <= pend_nxt;
      need       <= need_nxt;
      free_count <= CW'(NUM_PU) - pop;
      ready_en   <= 1'b1;
      if (hs) tag <= req_tag;
      if (rel_valid && |(rel_mask & ~busy)) rel_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pu_allocator.sv
// Randomized bench for pu_allocator against a set-level model of the PU pool.
module tb_pu_allocator;

  localparam int NPU = 16;
  localparam int CW  = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_valid = 1'b0, req_ready;
  logic [CW-1:0]  req_count = '0;
  logic [7:0]     req_tag = '0;
  logic           grant_valid, grant_ready = 1'b0;
  logic [NPU-1:0] grant_mask;
  logic [7:0]     grant_tag;
  logic           rel_valid = 1'b0;
  logic [NPU-1:0] rel_mask = '0;
  logic [CW-1:0]  free_count;
  logic           rel_err;

  int n_chk = 0, n_pass = 0;
  logic [NPU-1:0] busy_m = '0;
  bit err_m = 0;

  pu_allocator #(.NUM_PU(NPU), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_count(req_count), .req_tag(req_tag),
    .grant_valid(grant_valid), .grant_ready(grant_ready), .grant_mask(grant_mask), .grant_tag(grant_tag),
    .rel_valid(rel_valid), .rel_mask(rel_mask), .free_count(free_count), .rel_err(rel_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h exp 0x%0h", tag, got, exp);
  endtask

  function automatic logic [NPU-1:0] lowest(input logic [NPU-1:0] v);
    for (int i = 0; i < NPU; i++) if (v[i]) return NPU'(1) << i;
    return '0;
  endfunction

  function automatic int eff_of(input int c);
    return (c == 0) ? 1 : ((c > NPU) ? NPU : c);
  endfunction

  function automatic int n_of(input int c);
    int f;
    f = $countones(~busy_m);
`ifdef PU_ALLOC_PARTIAL_EN
    return (f < eff_of(c)) ? f : eff_of(c);
`else
    return eff_of(c);
`endif
  endfunction

  function automatic bit waits(input int c);
`ifdef PU_ALLOC_PARTIAL_EN
    return 0;
`else
    return $countones(~busy_m) < eff_of(c);
`endif
  endfunction

  function automatic void model_rel(input logic [NPU-1:0] r);
    if (|(r & ~busy_m)) err_m = 1;
    busy_m &= ~r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 0; grant_ready = 0; rel_valid = 0; rel_mask = '0;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_gvalid", grant_valid, 0);
    chk("rst_gmask", grant_mask, 0);
    chk("rst_gtag", grant_tag, 0);
    chk("rst_free", free_count, NPU);
    chk("rst_err", rel_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_pre_edge", req_ready, 0);
    @(negedge clk);
    chk("ready_post_edge", req_ready, 1);
    busy_m = '0;
    err_m  = 0;
  endtask

  task automatic pool_rel(input logic [NPU-1:0] r);
    @(negedge clk);
    rel_valid = 1; rel_mask = r;
    model_rel(r);
    @(negedge clk);
    rel_valid = 0; rel_mask = '0;
    chk("pool_free", free_count, NPU - $countones(busy_m));
    chk("pool_err", rel_err, err_m);
  endtask

  // One full request: handshake, allocation (optionally stalled), held grant, accept.
  task automatic do_req(input int cnt, input logic [7:0] t, input logic [NPU-1:0] wait_rel,
                        input logic [NPU-1:0] mid_rel, input int mid_k,
                        input logic [NPU-1:0] acc_rel, input int hold);
    int n, k;
    bit w, applied;
    logic [NPU-1:0] pend;
    n = n_of(cnt);
    w = waits(cnt);
    pend = '0;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    chk("req_ready", req_ready, 1);
    req_valid = 1; req_count = CW'(cnt); req_tag = t;
    @(negedge clk);
    req_valid = 0;
    if (w) begin
      repeat (2) @(negedge clk);
      chk("wait_no_grant", grant_valid, 0);
      chk("wait_free", free_count, NPU - $countones(busy_m));
      rel_valid = 1; rel_mask = wait_rel;
      model_rel(wait_rel);
      @(negedge clk);
      rel_valid = 0; rel_mask = '0;
      for (int j = 0; j < n; j++) pend |= lowest(~busy_m & ~pend);
      k = 0;
      while (!grant_valid && k < 60) begin @(negedge clk); k++; end
      chk("wait_latency", k, n + 2);
    end else begin
      applied = 0;
      for (int j = 1; j <= n; j++) begin
        if (|mid_rel && !applied && mid_k + 1 < j) begin model_rel(mid_rel); applied = 1; end
        pend |= lowest(~busy_m & ~pend);
      end
      if (|mid_rel && !applied) model_rel(mid_rel);
      k = 0;
      while (!grant_valid && k < 60) begin
        rel_valid = (|mid_rel) && (k == mid_k);
        rel_mask  = rel_valid ? mid_rel : '0;
        @(negedge clk);
        k++;
      end
      rel_valid = 0; rel_mask = '0;
      chk("latency", k, n + 1);
    end
    chk("grant_mask", grant_mask, pend);
    chk("grant_tag", grant_tag, t);
    chk("grant_free", free_count, NPU - $countones(busy_m | pend));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", grant_valid, 1);
      chk("hold_mask", grant_mask, pend);
      chk("hold_tag", grant_tag, t);
    end
    grant_ready = 1; rel_valid = |acc_rel; rel_mask = acc_rel;
    model_rel(acc_rel);
    busy_m |= pend;
    @(negedge clk);
    grant_ready = 0; rel_valid = 0; rel_mask = '0;
    chk("acc_valid", grant_valid, 0);
    chk("acc_free", free_count, NPU - $countones(busy_m));
    chk("acc_err", rel_err, err_m);
  endtask

  initial begin
    int c, seen;
    logic [NPU-1:0] wr, mr, ar;

    do_reset();
    do_req(4, 8'h11, '0, '0, 0, '0, 0);
    chk("first_free12", free_count, 12);
    do_req(8, 8'h22, '0, '0, 0, '0, 0);
`ifndef PU_ALLOC_PARTIAL_EN
    do_req(12, 8'h33, 16'h00FF, '0, 0, '0, 0);
    chk("waitfree_full", free_count, 0);
`else
    do_req(13, 8'h44, '0, '0, 0, '0, 0);
    chk("partial_free0", free_count, 0);
`endif

    do_reset();
    do_req(0, 8'h01, '0, '0, 0, '0, 1);
    do_reset();
    do_req(20, 8'h02, '0, '0, 0, '0, 0);
    chk("all_busy", free_count, 0);

    do_reset();
    do_req(12, 8'h40, '0, 16'h0100, 9, '0, 0);
    chk("pend_rel_err", rel_err, 1);
    do_req(2, 8'h41, '0, '0, 0, 16'h0001, 3);

`ifdef PU_ALLOC_PARTIAL_EN
    do_reset();
    do_req(13, 8'h50, '0, '0, 0, '0, 0);
    do_req(12, 8'h51, '0, '0, 0, '0, 0);
    chk("partial_3", free_count, 0);
`endif

    // Reset while allocating must drop the request.
    do_reset();
    req_valid = 1; req_count = CW'(5); req_tag = 8'h55;
    @(negedge clk);
    req_valid = 0;
    repeat (3) @(negedge clk);
    do_reset();
    seen = 0;
    repeat (10) begin @(negedge clk); if (grant_valid) seen = 1; end
    chk("rst_mid_nogrant", seen, 0);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 7) == 0) wr = NPU'($urandom);
      else wr = busy_m & NPU'($urandom);
`ifdef PU_ALLOC_PARTIAL_EN
      if (busy_m == '1) wr = busy_m;
`endif
      if (|wr) pool_rel(wr);
      c = $urandom_range(0, 20);
      wr = '0; mr = '0;
      if (waits(c)) begin
        wr = busy_m & NPU'($urandom);
        if ($countones(~(busy_m & ~wr)) < eff_of(c)) wr = busy_m;
      end else if ($urandom_range(0, 3) == 0) begin
        mr = NPU'($urandom & $urandom);
      end
      ar = busy_m & NPU'($urandom & $urandom);
      do_req(c, 8'($urandom), wr, mr, $urandom_range(0, n_of(c)), ar, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pu_allocator.md
PU_ALLOCATOR -- requirements
Module: pu_allocator

Interface
REQ-001 SHALL have parameter NUM_PU, default 16, giving the number of processing units managed.
REQ-002 SHALL have parameter CW, default $clog2(NUM_PU)+1, giving the width of counts.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  allocation request present.
REQ-006 req_ready  out  1  allocator accepts request this cycle.
REQ-007 req_count  in  CW  PUs requested, the preallocated PU count.
REQ-008 req_tag  in  8  opaque request tag.
REQ-009 grant_valid  out  1  grant_mask/grant_tag valid.
REQ-010 grant_ready  in  1  consumer accepts grant.
REQ-011 grant_mask  out  NUM_PU  one bit per granted PU.
REQ-012 grant_tag  out  8  tag of granted request.
REQ-013 rel_valid  in  1  release strobe.
REQ-014 rel_mask  in  NUM_PU  PUs returned to pool.
REQ-015 free_count  out  CW  number of PUs neither busy nor pending.
REQ-016 rel_err  out  1  sticky; illegal release seen.

Function
REQ-017 SHALL implement FSM IDLE, WAIT_FREE, ALLOC, GRANT.
REQ-018 SHALL assert req_ready only in IDLE; handshake = req_valid && req_ready.
REQ-019 SHALL latch req_count and req_tag at handshake, treating 0 as 1 and clamping values >NUM_PU to NUM_PU.
REQ-020 SHALL move IDLE->ALLOC if free_count >= effective count at handshake+1, else IDLE->WAIT_FREE.
REQ-021 SHALL leave WAIT_FREE for ALLOC on the first cycle free_count >= effective count.
REQ-022 In ALLOC SHALL reserve exactly one PU per cycle, the lowest-index free PU, setting its pending bit.
REQ-023 SHALL go ALLOC->GRANT after the count-th reservation; latency handshake to grant_valid = count+1 cycles when PUs are free.
REQ-024 In GRANT SHALL hold grant_valid=1 with grant_mask = pending mask and grant_tag stable until grant_ready.
REQ-025 On grant_valid && grant_ready SHALL move pending bits to busy, clear pending, and return to IDLE.
REQ-026 SHALL clear busy bits in rel_mask & busy whenever rel_valid, in any state, including the same cycle as an ALLOC reservation or grant acceptance.
REQ-027 Releasing a PU not busy, including pending bits, SHALL leave that bit unchanged and set rel_err.
REQ-028 free_count SHALL equal NUM_PU minus popcount(busy|pending), registered, and reflect updates the cycle after they occur.
REQ-029 A PU released in cycle N SHALL be selectable by ALLOC in cycle N+1.

Reset
REQ-030 On rst_n low SHALL force: state IDLE, busy=0, pending=0, req_ready=0 during reset, grant_valid=0, grant_mask=0, grant_tag=0, free_count=NUM_PU, rel_err=0.
REQ-031 Reset mid-ALLOC or mid-GRANT SHALL discard the in-flight request without emitting a grant.
REQ-032 req_ready SHALL assert on the first clk edge after rst_n deasserts.

Configuration
REQ-033 With PU_ALLOC_PARTIAL_EN defined, WAIT_FREE SHALL NOT be used. A request with free_count >= 1 SHALL allocate min(count, free_count) PUs. With free_count=0, the request SHALL wait for at least one PU to become free.
REQ-034 Without PU_ALLOC_PARTIAL_EN, grants SHALL always contain exactly the effective count of PUs (REQ-020/021).

Structure
REQ-035 NUM_PU, count width, and node_class encodings (00 normal, 01 medium, 10 high) SHALL live in shared package bfs_pkg.
REQ-036 Lowest-free selection SHALL be sub-module pu_find_first (NUM_PU-bit vector in, one-hot and found out, combinational).

Verification (NUM_PU=16)
REQ-037 Reset, req count=4 tag=0x11 -> grant_valid at cycle 5 after handshake, mask=0x000F, tag=0x11, free_count=12 after accept.
REQ-038 Busy=0x0FFF (12 used), req count=12 -> WAIT_FREE. rel 0x00FF -> ALLOC next cycle, grant mask=0xF0FF.
REQ-039 req count=0 -> grant of 1 PU (lowest free). req count=20 -> grant 0xFFFF.
REQ-040 rel_mask=0x0100 while PU8 is pending in ALLOC -> bit unchanged, rel_err=1, grant still includes PU8.
REQ-041 grant held 3 cycles with grant_ready=0 -> mask and tag stable. rel of another PU in the same cycle as grant accept -> both take effect, free_count correct next cycle.
REQ-042 With PU_ALLOC_PARTIAL_EN and 3 free PUs, req count=12 -> grant of those 3 PUs, no WAIT_FREE.
